axis_stream_fifo: RTL and testbench
===================================

// Module: axis_stream_fifo
// PURPOSE
//  Parametrised AXI4-Stream FIFO between a stream master and a stream slave; decouples their TVALID/TREADY
//  handshakes. Adds TLAST framing, a fill-level output and an optional store-and-forward packet mode.
//  Sits between the stream master and slave inside the AXI stream top.
// PARAMETERS
//  DATA_W   32  TDATA width in bits, >=1
//  DEPTH    16  storage entries; power of two, >=2
//  ADDR_W   $clog2(DEPTH)  derived; do not override
// PORTS
//  ACLK        in   1         clock, all logic on rising edge
//  ARSTN       in   1         reset, asynchronous, active-low
//  S_TDATA     in   DATA_W    upstream data
//  S_TVALID    in   1         upstream valid
//  S_TLAST     in   1         upstream end-of-packet
//  S_TREADY    out  1         FIFO can accept a beat
//  M_TDATA     out  DATA_W    downstream data (head entry)
//  M_TVALID    out  1         head entry valid to downstream
//  M_TLAST     out  1         head entry end-of-packet
//  M_TREADY    in   1         downstream ready
//  FILL_LEVEL  out  ADDR_W+1  entries stored, 0..DEPTH
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, FILL_LEVEL=0, M_TVALID=0, S_TREADY=0, pkt_cnt=0. rst_done flop sets 1 on first
//    edge after ARSTN rises; S_TREADY = rst_done & !full. ARSTN low mid-transfer discards all contents at once.
//  - Push on edge when S_TVALID&S_TREADY: {S_TLAST,S_TDATA} written at wr_ptr; wr_ptr++.
//  - Pop on edge when M_TVALID&M_TREADY: rd_ptr++.
//  - Pointers ADDR_W+1 bits, wrap naturally. empty: ptrs equal. full: MSBs differ, rest equal.
//  - FILL_LEVEL = wr_ptr-rd_ptr (mod 2^(ADDR_W+1)), registered-pointer derived, no extra cycle.
//  - First-word fall-through: M_TDATA/M_TLAST = mem[rd_ptr] (combinational read).
//    Beat pushed at edge N shows M_TVALID=1 in cycle after edge N. Latency 1 cycle.
//  - Full: S_TREADY=0. No pass-through when full: a same-cycle pop does not enable a push.
//  - Empty: M_TVALID=0. Empty with S_TVALID=1: beat stored, no same-cycle bypass.
//  - Push and pop in same cycle (neither full nor empty): both happen; FILL_LEVEL unchanged.
//  - M_TDATA/M_TLAST are don't-care while M_TVALID=0. Held stable while M_TVALID=1 & M_TREADY=0.
//  - AXI rule: once M_TVALID=1 it stays 1 until the pop. True in both modes: pkt_cnt/full only grow until a pop.
// CONFIGURATION
//  AXIS_FIFO_PACKET_MODE_EN defined: store-and-forward.
//   - pkt_cnt (ADDR_W+1 bits) counts stored TLAST beats: +1 on push with S_TLAST; -1 on pop with M_TLAST.
//   - Both in the same cycle leave pkt_cnt unchanged.
//   - M_TVALID = !empty & (pkt_cnt!=0 | full). The full term is the deadlock escape for packets > DEPTH:
//     such a packet streams out cut-through once full.
//  Undefined: M_TVALID = !empty. pkt_cnt logic is absent and TLAST is only carried through.
// STRUCTURE
//  - Shared package axis_pkg: AXIS_DATA_W_DEF=32, AXIS_DEPTH_DEF=16, clog2 helper function,
//    beat struct/typedef {last,data}. Used by all stream blocks.
//  - Sub-module axis_fifo_mem: DEPTH x (DATA_W+1) array, synchronous write port, asynchronous read port.
//  - Top holds pointers, flags, rst_done and pkt_cnt.
// TESTING  (DATA_W=32, DEPTH=4 unless stated)
//  1. Reset: ARSTN low 3 cycles with S_TVALID=1 -> S_TREADY=0, M_TVALID=0, FILL_LEVEL=0;
//     S_TREADY=1 one edge after release.
//  2. Fill: push 0xA0..0xA3, M_TREADY=0 -> FILL_LEVEL=4, S_TREADY=0; 5th beat 0xA4 held by master.
//     Drain -> 0xA0..0xA3 in order, then 0xA4.
//  3. Full + simultaneous: at FILL_LEVEL=4, M_TREADY=1 and S_TVALID=1 -> that cycle pop only;
//     next cycle push+pop, FILL_LEVEL stays 3.
//  4. Backpressure: random M_TREADY toggling over 1000 beats with TLAST every 3rd -> data/TLAST match
//     scoreboard; M_TDATA stable while stalled.
//  5. Packet mode (AXIS_FIFO_PACKET_MODE_EN): push 3 beats, last has TLAST=0 -> M_TVALID=0;
//     4th beat with TLAST=1 -> M_TVALID=1 next cycle.
//  6. Packet mode oversize: 6-beat packet into DEPTH=4 -> at full M_TVALID=1, all 6 beats delivered,
//     pkt_cnt returns to 0.
//  7. Reset mid-stream: ARSTN low with FILL_LEVEL=3 -> FILL_LEVEL=0, M_TVALID=0 asynchronously.

Source files
------------

// File: rtl/axis_pkg.sv
// axis_pkg: defaults, clog2 helper and beat type shared by the AXI4-Stream blocks.
// Rev 1.0
`default_nettype none

package axis_pkg;

    localparam int AXIS_DATA_W_DEF = 32;
    localparam int AXIS_DEPTH_DEF  = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic                       last;
        logic [AXIS_DATA_W_DEF-1:0] data;
    } axis_beat_t;

endpackage

`default_nettype wire

// File: rtl/axis_fifo_mem.sv
// axis_fifo_mem: DEPTH x WIDTH storage, synchronous write port, asynchronous read port.
// Rev 1.0
`default_nettype none

module axis_fifo_mem #(
    parameter int WIDTH  = 33,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array: contents are meaningless until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/axis_stream_fifo.sv
// axis_stream_fifo: first-word fall-through AXI4-Stream FIFO with TLAST framing and fill level.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward packet mode. Rev 1.0
`default_nettype none

module axis_stream_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W_DEF,
    parameter int DEPTH  = AXIS_DEPTH_DEF,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              ACLK,
    input  logic              ARSTN,
    input  logic [DATA_W-1:0] S_TDATA,
    input  logic              S_TVALID,
    input  logic              S_TLAST,
    output logic              S_TREADY,
    output logic [DATA_W-1:0] M_TDATA,
    output logic              M_TVALID,
    output logic              M_TLAST,
    input  logic              M_TREADY,
    output logic [ADDR_W:0]   FILL_LEVEL
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              rst_done;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   rd_beat;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // Readiness ignores a same-cycle pop: no pass-through when full.
    assign S_TREADY   = rst_done & ~full;
    assign push       = S_TVALID & S_TREADY;
    assign pop        = M_TVALID & M_TREADY;
    assign FILL_LEVEL = wr_ptr - rd_ptr;

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    axis_fifo_mem #(
        .WIDTH  (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (ACLK),
        .wr_en   (push),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data ({S_TLAST, S_TDATA}),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_beat)
    );

    assign M_TLAST = rd_beat[DATA_W];
    assign M_TDATA = rd_beat[DATA_W-1:0];

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [ADDR_W:0] pkt_cnt;

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            pkt_cnt <= '0;
        end else begin
            case ({push & S_TLAST, pop & M_TLAST})
                2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
                2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // The full term lets a packet longer than DEPTH drain cut-through instead of deadlocking.
    assign M_TVALID = ~empty & ((pkt_cnt != '0) | full);
`else
    assign M_TVALID = ~empty;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_stream_fifo.sv
// tb_axis_stream_fifo: randomized and directed checks of axis_stream_fifo against a queue model.
`default_nettype none

module tb_axis_stream_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              ACLK = 1'b0;
    logic              ARSTN;
    logic [DATA_W-1:0] S_TDATA;
    logic              S_TVALID;
    logic              S_TLAST;
    logic              S_TREADY;
    logic [DATA_W-1:0] M_TDATA;
    logic              M_TVALID;
    logic              M_TLAST;
    logic              M_TREADY;
    logic [ADDR_W:0]   FILL_LEVEL;

    axis_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .ACLK       (ACLK),
        .ARSTN      (ARSTN),
        .S_TDATA    (S_TDATA),
        .S_TVALID   (S_TVALID),
        .S_TLAST    (S_TLAST),
        .S_TREADY   (S_TREADY),
        .M_TDATA    (M_TDATA),
        .M_TVALID   (M_TVALID),
        .M_TLAST    (M_TLAST),
        .M_TREADY   (M_TREADY),
        .FILL_LEVEL (FILL_LEVEL)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: ordered list of stored beats {last, data}.
    logic [DATA_W:0] q[$];
    logic [DATA_W:0] drained[$];
    bit              m_rst_done;
    bit              last_push;
    bit              last_pop;
    int              n_pop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit exp_valid();
        int lasts;
        if (q.size() == 0) return 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
        lasts = 0;
        foreach (q[i]) if (q[i][DATA_W]) lasts++;
        return (lasts > 0) || (q.size() == DEPTH);
`else
        lasts = 0;
        return 1'b1 | (lasts != 0);
`endif
    endfunction

    function automatic bit exp_ready();
        return m_rst_done && (q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        q.delete();
        m_rst_done = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance the model on the rising edge.
    task automatic cycle();
        bit v;
        bit r;
        @(negedge ACLK);
        check("fill_level", 64'(FILL_LEVEL), 64'(q.size()));
        check("s_tready", 64'(S_TREADY), 64'(exp_ready()));
        check("m_tvalid", 64'(M_TVALID), 64'(exp_valid()));
        if (exp_valid()) begin
            check("m_tdata", 64'(M_TDATA), 64'(q[0][DATA_W-1:0]));
            check("m_tlast", 64'(M_TLAST), 64'(q[0][DATA_W]));
        end
        @(posedge ACLK);
        last_push = 1'b0;
        last_pop  = 1'b0;
        if (ARSTN) begin
            v = exp_valid();
            r = exp_ready();
            if (v && M_TREADY) begin
                drained.push_back(q.pop_front());
                last_pop = 1'b1;
                n_pop++;
            end
            if (S_TVALID && r) begin
                q.push_back({S_TLAST, S_TDATA});
                last_push = 1'b1;
            end
            m_rst_done = 1'b1;
        end
        #1;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
        int budget;
        S_TDATA  = d;
        S_TLAST  = l;
        S_TVALID = 1'b1;
        budget   = 0;
        do begin
            cycle();
            budget++;
        end while (!last_push && budget < 50);
        if (!last_push) check("send_timeout", 64'(budget), 64'(0));
        S_TVALID = 1'b0;
    endtask

    task automatic drain();
        int budget;
        S_TVALID = 1'b0;
        M_TREADY = 1'b1;
        budget   = 0;
        while (q.size() != 0 && budget < 100) begin
            cycle();
            budget++;
        end
        check("drain_empty", 64'(q.size()), 64'(0));
        cycle();
    endtask

    initial begin
        int cyc;
        int pushed;
        ARSTN    = 1'b0;
        S_TDATA  = '0;
        S_TVALID = 1'b1;
        S_TLAST  = 1'b0;
        M_TREADY = 1'b0;
        n_pop    = 0;
        model_reset();

        // Reset held with upstream valid asserted
        repeat (3) cycle();
        ARSTN    = 1'b1;
        S_TVALID = 1'b0;
        cycle();
        check("rst_ready", 64'(S_TREADY), 64'(1));

        // Fill to full, then full+simultaneous pop, then push+pop
        M_TREADY = 1'b0;
        drained.delete();
        for (int i = 0; i < 4; i++) send_beat(DATA_W'(32'hA0 + i), (i == 3));
        check("full_level", 64'(FILL_LEVEL), 64'(4));
        check("full_ready", 64'(S_TREADY), 64'(0));
        S_TDATA  = 32'hA4;
        S_TLAST  = 1'b1;
        S_TVALID = 1'b1;
        cycle();
        cycle();
        check("held_level", 64'(FILL_LEVEL), 64'(4));
        M_TREADY = 1'b1;
        cycle();
        check("full_pop_only", 64'(FILL_LEVEL), 64'(3));
        cycle();
        check("push_pop_level", 64'(FILL_LEVEL), 64'(3));
        S_TVALID = 1'b0;
        drain();
        check("drain_count", 64'(drained.size()), 64'(5));
        for (int i = 0; i < 5 && i < drained.size(); i++)
            check("drain_order", 64'(drained[i][DATA_W-1:0]), 64'(32'hA0 + i));

        // Randomized backpressure, TLAST every third beat
        n_pop  = 0;
        pushed = 0;
        cyc    = 0;
        while (n_pop < 1000 && cyc < 30000) begin
            if (!S_TVALID && pushed < 1000 && $urandom_range(3) != 0) begin
                S_TVALID = 1'b1;
                S_TDATA  = $urandom;
                S_TLAST  = (pushed % 3 == 2);
            end
            M_TREADY = $urandom_range(1);
            cycle();
            cyc++;
            if (last_push) begin
                pushed++;
                S_TVALID = 1'b0;
            end
        end
        check("rand_beats", 64'(n_pop), 64'(1000));
        drain();

`ifdef AXIS_FIFO_PACKET_MODE_EN
        // Partial packet is withheld until its TLAST arrives
        M_TREADY = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(DATA_W'(32'hB0 + i), 1'b0);
        cycle();
        check("pm_withheld", 64'(M_TVALID), 64'(0));
        send_beat(32'hB3, 1'b1);
        check("pm_release", 64'(M_TVALID), 64'(1));
        drain();

        // Oversize packet escapes via the full condition
        n_pop = 0;
        for (int i = 0; i < 6; i++) send_beat(DATA_W'(32'hC0 + i), (i == 5));
        drain();
        check("pm_oversize", 64'(n_pop), 64'(6));
        check("pm_pkt_cnt", 64'(dut.pkt_cnt), 64'(0));
`endif

        // Asynchronous reset with three beats stored
        M_TREADY = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(DATA_W'(32'hD0 + i), 1'b1);
        check("pre_rst_level", 64'(FILL_LEVEL), 64'(3));
        #2;
        ARSTN = 1'b0;
        model_reset();
        #1;
        check("async_rst_level", 64'(FILL_LEVEL), 64'(0));
        check("async_rst_valid", 64'(M_TVALID), 64'(0));
        cycle();
        ARSTN = 1'b1;
        cycle();
        M_TREADY = 1'b1;
        send_beat(32'hE0, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
